// File: rtl/mem_responder.sv
// Core-side RAM responder: arbitrates stores, loads and fetches onto one single-port SRAM
// with fixed read latency. Define MEM_RESPONDER_BYTE_STORE_EN for read-modify-write byte stores.
module mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int SRAM_AW = 10,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  instruction_address,
    input  logic               dm_read_en,
    input  logic               dm_write_en,
    input  logic               store_byte,
    input  logic [ADDR_W-1:0]  data_address,
    input  logic [31:0]        data_to_write,
    output logic [31:0]        instruction_read,
    output logic [31:0]        data_read,
    output logic               fetch_done,
    output logic               data_done,
    output logic               busy,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_ren,
    output logic               sram_wen,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR      = 3'd2,
`ifdef MEM_RESPONDER_BYTE_STORE_EN
        ST_RMW_RD  = 3'd3,
        ST_RMW_WR  = 3'd4,
`endif
        ST_DONE    = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [2:0]         cnt_r;
    logic [2:0]         cnt_s;
    logic               is_fetch_r;
    logic               is_fetch_s;
    logic [SRAM_AW-1:0] addr_s;
    logic [31:0]        wdata_s;
    logic [31:0]        iread_s;
    logic [31:0]        dread_s;
    logic               ren_s;
    logic               wen_s;
    logic               fdone_s;
    logic               ddone_s;
    logic               busy_s;
    logic               unused_s;

`ifdef MEM_RESPONDER_BYTE_STORE_EN
    logic [1:0]         lane_r;
    logic [1:0]         lane_s;
    logic [7:0]         byte_r;
    logic [7:0]         byte_s;

    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
        logic [31:0] merged;
        merged = word;
        merged[{lane, 3'b000} +: 8] = data;
        return merged;
    endfunction

    assign unused_s = ^{instruction_address[1:0], instruction_address[ADDR_W-1:SRAM_AW+2],
                        data_address[ADDR_W-1:SRAM_AW+2]};
`else
    assign unused_s = ^{instruction_address[1:0], instruction_address[ADDR_W-1:SRAM_AW+2],
                        data_address[ADDR_W-1:SRAM_AW+2], data_address[1:0], store_byte};
`endif

    // Next-state and next-output logic; every output is the registered copy of these values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        is_fetch_s = is_fetch_r;
        addr_s     = sram_addr;
        wdata_s    = sram_wdata;
        iread_s    = instruction_read;
        dread_s    = data_read;
        ren_s      = 1'b0;
        wen_s      = 1'b0;
        fdone_s    = 1'b0;
        ddone_s    = 1'b0;
`ifdef MEM_RESPONDER_BYTE_STORE_EN
        lane_s     = lane_r;
        byte_s     = byte_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (dm_write_en) begin
                    is_fetch_s = 1'b0;
                    addr_s     = data_address[SRAM_AW+1:2];
`ifdef MEM_RESPONDER_BYTE_STORE_EN
                    if (store_byte) begin
                        state_s = ST_RMW_RD;
                        ren_s   = 1'b1;
                        cnt_s   = 3'd0;
                        lane_s  = data_address[1:0];
                        byte_s  = data_to_write[7:0];
                    end else begin
                        state_s = ST_WR;
                        wen_s   = 1'b1;
                        wdata_s = data_to_write;
                    end
`else
                    state_s = ST_WR;
                    wen_s   = 1'b1;
                    wdata_s = data_to_write;
`endif
                end else if (dm_read_en) begin
                    state_s    = ST_RD_WAIT;
                    ren_s      = 1'b1;
                    cnt_s      = 3'd0;
                    is_fetch_s = 1'b0;
                    addr_s     = data_address[SRAM_AW+1:2];
                end else if (fetch_req) begin
                    state_s    = ST_RD_WAIT;
                    ren_s      = 1'b1;
                    cnt_s      = 3'd0;
                    is_fetch_s = 1'b1;
                    addr_s     = instruction_address[SRAM_AW+1:2];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_r == RD_LAT_C) begin
                    state_s = ST_DONE;
                    if (is_fetch_r) begin
                        iread_s = sram_rdata;
                        fdone_s = 1'b1;
                    end else begin
                        dread_s = sram_rdata;
                        ddone_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_WR: begin
                state_s = ST_DONE;
                ddone_s = 1'b1;
            end
`ifdef MEM_RESPONDER_BYTE_STORE_EN
            ST_RMW_RD: begin
                if (cnt_r == RD_LAT_C) begin
                    state_s = ST_RMW_WR;
                    wen_s   = 1'b1;
                    wdata_s = merge_byte(sram_rdata, lane_r, byte_r);
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_RMW_WR: begin
                state_s = ST_DONE;
                ddone_s = 1'b1;
            end
`endif
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset clears strobes immediately to abort any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            cnt_r            <= 3'd0;
            is_fetch_r       <= 1'b0;
            sram_addr        <= '0;
            sram_wdata       <= 32'd0;
            instruction_read <= 32'd0;
            data_read        <= 32'd0;
            sram_ren         <= 1'b0;
            sram_wen         <= 1'b0;
            fetch_done       <= 1'b0;
            data_done        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state_r          <= state_s;
            cnt_r            <= cnt_s;
            is_fetch_r       <= is_fetch_s;
            sram_addr        <= addr_s;
            sram_wdata       <= wdata_s;
            instruction_read <= iread_s;
            data_read        <= dread_s;
            sram_ren         <= ren_s;
            sram_wen         <= wen_s;
            fetch_done       <= fdone_s;
            data_done        <= ddone_s;
            busy             <= busy_s;
        end
    end

`ifdef MEM_RESPONDER_BYTE_STORE_EN
    // Byte-store lane and data held for the write-back half of the read-modify-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_r <= 2'd0;
            byte_r <= 8'd0;
        end else begin
            lane_r <= lane_s;
            byte_r <= byte_s;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: SRAM model with fixed read latency plus a
// transaction-level memory reference; directed steps followed by random transactions.
module tb_mem_responder;

    localparam int ADDR_W  = 32;
    localparam int SRAM_AW = 10;
    localparam int RD_LAT  = 2;
    localparam int DEPTH   = 1 << SRAM_AW;

    logic               clk;
    logic               rst;
    logic               fetch_req;
    logic [ADDR_W-1:0]  instruction_address;
    logic               dm_read_en;
    logic               dm_write_en;
    logic               store_byte;
    logic [ADDR_W-1:0]  data_address;
    logic [31:0]        data_to_write;
    logic [31:0]        instruction_read;
    logic [31:0]        data_read;
    logic               fetch_done;
    logic               data_done;
    logic               busy;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_ren;
    logic               sram_wen;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int txn_no   = 0;

    mem_responder #(.ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .instruction_address(instruction_address),
        .dm_read_en(dm_read_en), .dm_write_en(dm_write_en), .store_byte(store_byte),
        .data_address(data_address), .data_to_write(data_to_write),
        .instruction_read(instruction_read), .data_read(data_read),
        .fetch_done(fetch_done), .data_done(data_done), .busy(busy),
        .sram_addr(sram_addr), .sram_ren(sram_ren), .sram_wen(sram_wen),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // SRAM model: unwritten words read as init_word, data appears RD_LAT cycles after ren.
    logic [31:0]        sram_mem [0:DEPTH-1];
    bit                 sram_written [0:DEPTH-1];
    bit   [SRAM_AW-1:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (sram_wen) begin
            sram_mem[sram_addr]     <= sram_wdata;
            sram_written[sram_addr] <= 1'b1;
        end
        if (sram_ren) rd_pipe[0] <= sram_addr;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    always_comb begin
        sram_rdata = sram_written[rd_pipe[RD_LAT-1]] ? sram_mem[rd_pipe[RD_LAT-1]]
                                                     : init_word(32'(rd_pipe[RD_LAT-1]));
    end

    logic [31:0] ref_mem [0:DEPTH-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (txn %0d) observed=0x%08h expected=0x%08h", tag, txn_no, obs, exp);
        end
    endtask

    task automatic randomize_side_inputs();
        instruction_address = $urandom;
        data_address        = $urandom;
        data_to_write       = $urandom;
        store_byte          = 1'($urandom);
    endtask

    // kind: 0 fetch, 1 load, 2 word store, 3 byte store; extra raises all lower-priority requests too.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wd, input bit extra);
        int          idx, eff, lane;
        int          exp_ren_c, exp_wen_c, exp_done_c;
        int          ren_c, wen_c, done_c, n_ren, n_wen, n_both, n_good, n_bad, n_notbusy;
        logic [31:0] ren_a, wen_a, wen_d, exp_d;
        logic        after_busy, good, bad;
        txn_no++;
        idx  = int'(addr[SRAM_AW+1:2]);
        lane = int'(addr[1:0]);
        eff  = kind;
`ifndef MEM_RESPONDER_BYTE_STORE_EN
        if (kind == 3) eff = 2;
`endif
        case (eff)
            0, 1: begin exp_ren_c = 1;  exp_wen_c = -1; exp_done_c = RD_LAT + 2; exp_d = ref_mem[idx]; end
            2:    begin exp_ren_c = -1; exp_wen_c = 1;  exp_done_c = 2;          exp_d = wd; end
            default: begin
                exp_ren_c  = 1;
                exp_wen_c  = RD_LAT + 2;
                exp_done_c = RD_LAT + 3;
                exp_d = (ref_mem[idx] & ~(32'h0000_00FF << (8 * lane))) | (32'(wd[7:0]) << (8 * lane));
            end
        endcase

        randomize_side_inputs();
        fetch_req   = (kind == 0) || extra;
        dm_read_en  = (kind == 1) || (extra && kind >= 2);
        dm_write_en = (kind >= 2);
        if (kind >= 2) store_byte = (kind == 3);
        if (kind == 0) instruction_address = addr;
        else           data_address        = addr;
        if (kind >= 2) data_to_write = wd;
        @(posedge clk); #1;
        fetch_req = 1'b0; dm_read_en = 1'b0; dm_write_en = 1'b0;
        randomize_side_inputs();

        ren_c = -1; wen_c = -1; done_c = -1; n_ren = 0; n_wen = 0; n_both = 0;
        n_good = 0; n_bad = 0; n_notbusy = 0; ren_a = '0; wen_a = '0; wen_d = '0; after_busy = 1'bx;
        for (int c = 1; c <= 30; c++) begin
            if (done_c >= 0 && c == done_c + 1) begin
                after_busy = busy;
                if (sram_ren || sram_wen) n_both++;
                break;
            end
            good = (kind == 0) ? fetch_done : data_done;
            bad  = (kind == 0) ? data_done  : fetch_done;
            if (sram_ren) begin n_ren++; ren_c = c; ren_a = 32'(sram_addr); end
            if (sram_wen) begin n_wen++; wen_c = c; wen_a = 32'(sram_addr); wen_d = sram_wdata; end
            if (sram_ren && sram_wen) n_both++;
            if (!busy) n_notbusy++;
            if (bad) n_bad++;
            if (good) begin n_good++; done_c = c; end
            @(posedge clk); #1;
        end

        if (eff >= 2) ref_mem[idx] = exp_d;

        chk("ren_count", n_ren, (exp_ren_c > 0) ? 1 : 0);
        if (exp_ren_c > 0) begin
            chk("ren_cycle", ren_c, exp_ren_c);
            chk("ren_addr", ren_a, idx);
        end
        chk("wen_count", n_wen, (exp_wen_c > 0) ? 1 : 0);
        if (exp_wen_c > 0) begin
            chk("wen_cycle", wen_c, exp_wen_c);
            chk("wen_addr", wen_a, idx);
            chk("wen_data", wen_d, exp_d);
        end
        chk("done_cycle", done_c, exp_done_c);
        chk("done_count", n_good, 1);
        chk("wrong_done", n_bad, 0);
        chk("strobe_overlap", n_both, 0);
        chk("busy_during", n_notbusy, 0);
        chk("busy_after", 32'(after_busy), 0);
        if (eff == 0) chk("instruction_read", instruction_read, exp_d);
        if (eff == 1) chk("data_read", data_read, exp_d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, n_strobe, n_busy, n_ddone;
        logic [31:0] a, d;
        logic [31:0] byte_exp;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        rst = 1'b1;
        fetch_req = 1'($urandom); dm_read_en = 1'($urandom); dm_write_en = 1'($urandom);
        randomize_side_inputs();
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            fetch_req = 1'($urandom); dm_read_en = 1'($urandom); dm_write_en = 1'($urandom);
            randomize_side_inputs();
        end
        chk("rst_instruction_read", instruction_read, 0);
        chk("rst_data_read", data_read, 0);
        chk("rst_fetch_done", 32'(fetch_done), 0);
        chk("rst_data_done", 32'(data_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_sram_ren", 32'(sram_ren), 0);
        chk("rst_sram_wen", 32'(sram_wen), 0);
        chk("rst_sram_wdata", sram_wdata, 0);

        fetch_req = 1'b0; dm_read_en = 1'b0; dm_write_en = 1'b0;
        rst = 1'b1;
        n_strobe = 0; n_busy = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (sram_ren || sram_wen) n_strobe++;
            if (busy) n_busy++;
        end
        chk("idle_no_strobe", n_strobe, 0);
        chk("idle_no_busy", n_busy, 0);

        // Wrap check comes first so word 0 still holds its initial contents.
        run_txn(0, 32'h0000_1000, 32'd0, 1'b0);
        chk("wrap_fetch_word0", instruction_read, init_word(0));

        run_txn(2, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
        run_txn(1, 32'h0000_0040, 32'd0, 1'b0);
        chk("store_load_deadbeef", data_read, 32'hDEAD_BEEF);

        run_txn(2, 32'h0000_0080, 32'hCAFE_F00D, 1'b1);
        run_txn(1, 32'h0000_0080, 32'd0, 1'b1);
        chk("priority_store_won", data_read, 32'hCAFE_F00D);

        run_txn(2, 32'h0000_0040, 32'h1122_3344, 1'b0);
        run_txn(3, 32'h0000_0042, 32'h0000_00AA, 1'b0);
        run_txn(1, 32'h0000_0040, 32'd0, 1'b0);
`ifdef MEM_RESPONDER_BYTE_STORE_EN
        byte_exp = 32'h11AA_3344;
`else
        byte_exp = 32'h0000_00AA;
`endif
        chk("byte_store_word", data_read, byte_exp);

        data_address = 32'h0000_0100;
        dm_read_en = 1'b1;
        @(posedge clk); #1;
        dm_read_en = 1'b0;
        chk("midrst_ren_before", 32'(sram_ren), 1);
        rst = 1'b0;
        #1;
        chk("midrst_ren_async", 32'(sram_ren), 0);
        chk("midrst_busy_async", 32'(busy), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        n_strobe = 0; n_busy = 0; n_ddone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (sram_ren || sram_wen) n_strobe++;
            if (busy) n_busy++;
            if (data_done) n_ddone++;
        end
        chk("midrst_no_done", n_ddone, 0);
        chk("midrst_no_strobe", n_strobe, 0);
        chk("midrst_no_busy", n_busy, 0);
        run_txn(1, 32'h0000_0100, 32'd0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 3);
            a = $urandom & 32'hFFFF_F03F;
            d = $urandom;
            run_txn(k, a, d, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
